// File: rtl/breath_seq_if.sv
// breath_seq_if: control strobes in and brightness/colour status out for the breathing sequencer
interface breath_seq_if #(parameter int DUTY_W = 8);
    logic              en_i;
    logic              tick_i;
    logic              load_i;
    logic [2:0]        color_i;
    logic [DUTY_W-1:0] duty_o;
    logic [2:0]        color_o;
    logic              pwm_o;
    logic              busy_o;
    logic              breath_done_o;
    modport master (
        output en_i, tick_i, load_i, color_i,
        input  duty_o, color_o, pwm_o, busy_o, breath_done_o
    );
    modport slave (
        input  en_i, tick_i, load_i, color_i,
        output duty_o, color_o, pwm_o, busy_o, breath_done_o
    );
endinterface

// File: rtl/breath_seq.sv
// breath_seq: ramps a PWM duty up/down per breath and steps the colour index at each breath end
module breath_seq #(
    parameter int DUTY_W     = 8,
    parameter int HOLD_TICKS = 16,
    parameter int OFF_TICKS  = 16,
    parameter int NUM_COLORS = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    breath_seq_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, RISE, HOLD, FALL, DARK} state_t;

    localparam logic [DUTY_W-1:0] MAX = '1;
    localparam int CNT_MAX = (HOLD_TICKS > OFF_TICKS) ? HOLD_TICKS : OFF_TICKS;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [2:0] LAST_COLOR = 3'(NUM_COLORS - 1);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        color_q, color_d;
    logic              pend_q, pend_d;
    logic [2:0]        pend_color_q, pend_color_d;
    logic              done_q, done_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic              pwm_q, pwm_d;
    logic              load_ok;
    logic [2:0]        color_inc;

    assign load_ok   = bus.load_i && (int'(bus.color_i) < NUM_COLORS);
    assign color_inc = (color_q == LAST_COLOR) ? 3'd0 : color_q + 3'd1;

    assign bus.duty_o        = duty_q;
    assign bus.color_o       = color_q;
    assign bus.pwm_o         = pwm_q;
    assign bus.busy_o        = state_q != IDLE;
    assign bus.breath_done_o = done_q;

    // Breath phase sequencing, colour selection and PWM comparison
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        cnt_d        = cnt_q;
        color_d      = color_q;
        pend_d       = pend_q;
        pend_color_d = pend_color_q;
        done_d       = 1'b0;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;
        pwm_d        = pwm_cnt_q < duty_q;
        if (state_q == IDLE) begin
            if (load_ok) color_d = bus.color_i;
            if (bus.en_i) begin
                state_d = RISE;
                duty_d  = '0;
                cnt_d   = '0;
            end
        end else if (!bus.en_i) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
            if (load_ok) begin
                pend_d       = 1'b1;
                pend_color_d = bus.color_i;
            end
        end else begin
            if (load_ok) begin
                pend_d       = 1'b1;
                pend_color_d = bus.color_i;
            end
            if (bus.tick_i) begin
                case (state_q)
                    RISE: if (duty_q == MAX) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else duty_d = duty_q + 1'b1;
                    HOLD: if (cnt_q == HOLD_LAST) begin
                        state_d = FALL;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + 1'b1;
                    FALL: if (duty_q == '0) begin
                        state_d = DARK;
                        cnt_d   = '0;
                    end else duty_d = duty_q - 1'b1;
                    DARK: if (cnt_q == OFF_LAST) begin
                        state_d = RISE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        color_d = load_ok ? bus.color_i : (pend_q ? pend_color_q : color_inc);
                        pend_d  = 1'b0;
                    end else cnt_d = cnt_q + 1'b1;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            duty_q       <= '0;
            cnt_q        <= '0;
            color_q      <= '0;
            pend_q       <= 1'b0;
            pend_color_q <= '0;
            done_q       <= 1'b0;
            pwm_cnt_q    <= '0;
            pwm_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            cnt_q        <= cnt_d;
            color_q      <= color_d;
            pend_q       <= pend_d;
            pend_color_q <= pend_color_d;
            done_q       <= done_d;
            pwm_cnt_q    <= pwm_cnt_d;
            pwm_q        <= pwm_d;
        end
    end
endmodule

// File: tb/tb_breath_seq.sv
// tb_breath_seq: directed and random stimulus against a phase-position model of the breath
module tb_breath_seq;
    localparam int DW = 4;
    localparam int H = 2;
    localparam int O = 2;
    localparam int NC = 6;
    localparam int MAXV = (1 << DW) - 1;
    localparam int BREATH = 2 * (MAXV + 1) + H + O;
    localparam int FALL_K = MAXV + 1 + H;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    breath_seq_if #(.DUTY_W(DW)) bus();
    breath_seq #(.DUTY_W(DW), .HOLD_TICKS(H), .OFF_TICKS(O), .NUM_COLORS(NC)) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    bit m_idle = 1'b1;
    int m_k = 0;
    int m_color = 0;
    int m_pend = -1;
    int m_done = 0;
    int m_pulses = 0;
    int n_pulses = 0;
    int highs = 0;

    // Brightness as a function of ticks elapsed since the breath started
    function automatic int duty_of(int k);
        return (k <= MAXV) ? k : (k < FALL_K) ? MAXV : (k <= FALL_K + MAXV) ? FALL_K + MAXV - k : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(bit e, bit t, bit l, logic [2:0] c);
        bit valid;
        bus.en_i = e;
        bus.tick_i = t;
        bus.load_i = l;
        bus.color_i = c;
        @(posedge clk);
        valid = l && (int'(c) < NC);
        m_done = 0;
        if (m_idle) begin
            if (valid) m_color = int'(c);
            if (e) begin
                m_idle = 1'b0;
                m_k = 0;
            end
        end else if (!e) begin
            m_idle = 1'b1;
            m_k = 0;
            if (valid) m_pend = int'(c);
        end else begin
            if (valid) m_pend = int'(c);
            if (t) begin
                m_k++;
                if (m_k == BREATH) begin
                    m_k = 0;
                    m_done = 1;
                    m_pulses++;
                    m_color = (m_pend >= 0) ? m_pend : (m_color + 1) % NC;
                    m_pend = -1;
                end
            end
        end
        #1;
        chk("duty", 32'(bus.duty_o), m_idle ? 0 : duty_of(m_k));
        chk("color", 32'(bus.color_o), m_color);
        chk("busy", 32'(bus.busy_o), m_idle ? 0 : 1);
        chk("done", 32'(bus.breath_done_o), m_done);
        if (bus.breath_done_o) n_pulses++;
    endtask

    task automatic advance_to(int target);
        int g = 0;
        while (m_k != target && g < 200) begin
            step(1'b1, 1'b1, 1'b0, 3'd0);
            g++;
        end
    endtask

    initial begin
        bus.en_i = 1'b0;
        bus.tick_i = 1'b0;
        bus.load_i = 1'b0;
        bus.color_i = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_duty", 32'(bus.duty_o), 0);
        chk("rst_color", 32'(bus.color_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.breath_done_o), 0);
        chk("rst_pwm", 32'(bus.pwm_o), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        repeat (BREATH) step(1'b1, 1'b1, 1'b0, 3'd0);
        chk("first_pulses", n_pulses, 1);
        chk("first_color", 32'(bus.color_o), 1);
        repeat (6 * BREATH) begin
            if ($urandom_range(0, 2) == 0) step(1'b1, 1'b0, 1'b0, 3'd0);
            step(1'b1, 1'b1, 1'b0, 3'd0);
        end
        chk("wrap_pulses", n_pulses, 7);
        chk("wrap_color", 32'(bus.color_o), 1);
        advance_to(5);
        step(1'b1, 1'b1, 1'b1, 3'd4);
        chk("pend_hold", 32'(bus.color_o), 1);
        advance_to(10);
        step(1'b1, 1'b0, 1'b1, 3'd7);
        advance_to(0);
        chk("pend_color", 32'(bus.color_o), 4);
        advance_to(BREATH - 1);
        step(1'b1, 1'b1, 1'b1, 3'd2);
        chk("boundary_color", 32'(bus.color_o), 2);
        advance_to(FALL_K + MAXV - 9);
        chk("abort_pre", 32'(bus.duty_o), 9);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        chk("abort_duty", 32'(bus.duty_o), 0);
        chk("abort_color", 32'(bus.color_o), 2);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        chk("restart_duty", 32'(bus.duty_o), 1);
        repeat (400) step($urandom_range(0, 19) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
        step(1'b1, 1'b0, 1'b0, 3'd0);
        advance_to(5);
        repeat (2) step(1'b1, 1'b0, 1'b0, 3'd0);
        repeat (16) begin
            step(1'b1, 1'b0, 1'b0, 3'd0);
            highs += int'(bus.pwm_o);
        end
        chk("pwm_high", highs, 5);
        advance_to(MAXV + 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(bus.duty_o), 0);
        chk("arst_color", 32'(bus.color_o), 0);
        chk("arst_busy", 32'(bus.busy_o), 0);
        chk("arst_done", 32'(bus.breath_done_o), 0);
        chk("arst_pwm", 32'(bus.pwm_o), 0);
        m_idle = 1'b1;
        m_k = 0;
        m_color = 0;
        m_pend = -1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 3'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
